// File: rtl/ula_ar_commit_stage.sv
// Commit stage behind the arithmetic ULA: 2-entry skid buffer plus architectural {O,C,S,Z} flag register.
// Optional sticky overflow flag enabled by defining STICKY_OVF_EN.
module ula_ar_commit_stage #(
  parameter int BITS = 16,
  parameter int RD_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_resu,
  input  logic            in_o,
  input  logic            in_c,
  input  logic            in_s,
  input  logic            in_z,
  input  logic [4:0]      in_op,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_we,
  input  logic            in_fupd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_resu,
  output logic [4:0]      out_op,
  output logic [RD_W-1:0] out_rd,
  output logic            out_we,
  output logic [3:0]      flags_q,
  output logic            ovf_sticky,
  input  logic            ovf_clr
);

  logic [BITS-1:0] resu_mem [2];
  logic [3:0]      flg_mem  [2];
  logic [4:0]      op_mem   [2];
  logic [RD_W-1:0] rd_mem   [2];
  logic [1:0]      we_mem;
  logic [1:0]      fupd_mem;

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       commit;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // A flush cancels the cycle's pop, so it cannot commit flags either.
  assign commit    = pop & ~flush & fupd_mem[rd_ptr];

  assign out_resu = resu_mem[rd_ptr];
  assign out_op   = op_mem[rd_ptr];
  assign out_rd   = rd_mem[rd_ptr];
  assign out_we   = out_valid & we_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      resu_mem[wr_ptr] <= in_resu;
      flg_mem[wr_ptr]  <= {in_o, in_c, in_s, in_z};
      op_mem[wr_ptr]   <= in_op;
      rd_mem[wr_ptr]   <= in_rd;
      we_mem[wr_ptr]   <= in_we;
      fupd_mem[wr_ptr] <= in_fupd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      flags_q <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (commit) flags_q <= flg_mem[rd_ptr];
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (commit && flg_mem[rd_ptr][3]) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_ula_ar_commit_stage.sv
// Scoreboard bench for ula_ar_commit_stage at BITS=3: driver issues directed entries, negedge monitor checks.
module tb_ula_ar_commit_stage;

  typedef struct packed {
    logic [2:0] resu;
    logic [3:0] flg;
    logic [4:0] op;
    logic [3:0] rd;
    logic       we;
    logic       fupd;
  } ent_t;

`ifdef STICKY_OVF_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  ent_t       cur = '0;
  logic       in_ready, out_valid, out_we, ovf_sticky;
  logic [2:0] out_resu;
  logic [4:0] out_op;
  logic [3:0] out_rd;
  logic [3:0] flags_q;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ent_t       q[$];
  logic [3:0] mflags = '0;
  logic       msticky = 1'b0;

  ula_ar_commit_stage #(.BITS(3), .RD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_resu(cur.resu), .in_o(cur.flg[3]), .in_c(cur.flg[2]), .in_s(cur.flg[1]), .in_z(cur.flg[0]),
    .in_op(cur.op), .in_rd(cur.rd), .in_we(cur.we), .in_fupd(cur.fupd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_resu(out_resu), .out_op(out_op), .out_rd(out_rd), .out_we(out_we),
    .flags_q(flags_q), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares against the queue model, then advances the model by this cycle's handshakes.
  always @(negedge clk) begin
    int unsigned qs;
    logic do_push, do_pop, set;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      mflags  = '0;
      msticky = 1'b0;
    end else begin
      qs = q.size();
      chk("out_valid", out_valid, qs != 0);
      chk("in_ready", in_ready, qs < 2);
      chk("flags_q", flags_q, mflags);
      chk("ovf_sticky", ovf_sticky, msticky);
      if (out_valid && qs != 0)
        chk("head", {out_resu, out_op, out_rd, out_we}, {q[0].resu, q[0].op, q[0].rd, q[0].we});
      do_push = in_valid && (qs < 2);
      do_pop  = out_ready && (qs != 0);
      set = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) begin
          e = q.pop_front();
          if (e.fupd) begin
            mflags = e.flg;
            set    = e.flg[3];
          end
        end
        if (do_push) q.push_back(cur);
      end
      if (STK) begin
        if (set) msticky = 1'b1;
        else if (ovf_clr) msticky = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents e and holds it until accepted; leaves in_valid high for back-to-back sends.
  task automatic send(input ent_t e);
    logic acc;
    cur = e;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  function automatic ent_t mk(input logic [2:0] r, input logic [3:0] f, input logic [4:0] op,
                              input logic [3:0] rd, input logic fu);
    ent_t e;
    e.resu = r; e.flg = f; e.op = op; e.rd = rd; e.we = rd[0]; e.fupd = fu;
    return e;
  endfunction

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", flags_q, 4'b0000);
    chk("rst_sticky", ovf_sticky, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single entry: visible one cycle after push, flags committed at the pop edge
    out_ready = 1'b1;
    send(mk(3'b000, 4'b0101, 5'd3, 4'd1, 1'b1));
    in_valid = 1'b0;
    chk("lat_valid", out_valid, 1);
    chk("lat_resu", out_resu, 3'b000);
    chk("lat_flags_before", flags_q, 4'b0000);
    tick();
    chk("commit_flags", flags_q, 4'b0101);
    chk("drained", out_valid, 0);

    // Fill with out_ready low; third entry waits until a drain frees space
    out_ready = 1'b0;
    fork
      begin
        send(mk(3'b111, 4'b1111, 5'd10, 4'd2, 1'b0));
        send(mk(3'b100, 4'b0000, 5'd11, 4'd3, 1'b0));
        chk("full_in_ready", in_ready, 0);
        send(mk(3'b011, 4'b1010, 5'd12, 4'd4, 1'b0));
        in_valid = 1'b0;
      end
      begin
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();

    // Steady push+pop at count=1 keeps occupancy at one and wraps pointers
    send(mk(3'b001, 4'b0001, 5'd20, 4'd5, 1'b0));
    for (int i = 0; i < 4; i++) begin
      send(mk(3'(i + 2), 4'b0010, 5'(21 + i), 4'(6 + i), 1'b0));
      chk("steady_valid", out_valid, 1);
      chk("steady_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // fupd=0 commit leaves flags alone
    send(mk(3'b110, 4'b1111, 5'd30, 4'd7, 1'b0));
    in_valid = 1'b0;
    repeat (2) tick();
    chk("nofupd_flags", flags_q, 4'b0101);

    // Flush with buffer full: same-cycle push and pop (with commit) are dropped
    out_ready = 1'b0;
    send(mk(3'b101, 4'b1010, 5'd31, 4'd8, 1'b1));
    send(mk(3'b010, 4'b1100, 5'd1, 4'd9, 1'b1));
    cur = mk(3'b111, 4'b0011, 5'd2, 4'd10, 1'b1);
    in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_flags", flags_q, 4'b0101);
    repeat (2) tick();

    // Sticky overflow sequence
    send(mk(3'b001, 4'b1000, 5'd4, 4'd1, 1'b1));
    in_valid = 1'b0;
    tick();
    chk("stk_set", ovf_sticky, STK);
    chk("stk_flags", flags_q, 4'b1000);
    send(mk(3'b010, 4'b0010, 5'd5, 4'd2, 1'b1));
    in_valid = 1'b0;
    tick();
    chk("stk_hold", ovf_sticky, STK);
    send(mk(3'b011, 4'b1000, 5'd6, 4'd3, 1'b1));
    in_valid = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("stk_set_wins", ovf_sticky, STK);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("stk_clear", ovf_sticky, 0);

    // Asynchronous reset with entries buffered
    out_ready = 1'b0;
    send(mk(3'b100, 4'b0110, 5'd7, 4'd4, 1'b1));
    send(mk(3'b101, 4'b0111, 5'd8, 4'd5, 1'b1));
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_flags", flags_q, 4'b0000);
    chk("arst_sticky", ovf_sticky, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
